// File: rtl/apb_master.sv
// apb_master: APB4 requester; runs one SETUP/ACCESS transfer per accepted command.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES.
module apb_master #(
  parameter int REGWIDTH       = 32,
  parameter int G_ADDR_WIDTH   = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REGWIDTH-1:0]     cmd_wdata,
  input  logic [REGWIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [REGWIDTH-1:0]     rsp_rdata,
  output logic                    rsp_err,
  output logic                    m_apb_psel,
  output logic                    m_apb_penable,
  output logic                    m_apb_pwrite,
  output logic [2:0]              m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [REGWIDTH-1:0]     m_apb_pwdata,
  output logic [REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                    m_apb_pready,
  input  logic [REGWIDTH-1:0]     m_apb_prdata,
  input  logic                    m_apb_pslverr
);

  localparam int STRBW = REGWIDTH / 8;

  if (REGWIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master: REGWIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_next;
  logic                    write_q;
  logic [2:0]              prot_q;
  logic [G_ADDR_WIDTH-1:0] addr_q;
  logic [REGWIDTH-1:0]     wdata_q;
  logic [STRBW-1:0]        strb_q;
  logic [REGWIDTH-1:0]     rdata_q;
  logic                    err_q;
  logic                    accept;
  logic                    done;
  logic                    timeout;

  assign accept = (state == IDLE) && cmd_valid;
  assign done   = (state == ACCESS) && m_apb_pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  // Cleared during SETUP so the first ACCESS cycle sees zero; pready in the limit cycle still wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (state == SETUP)
      wait_cnt <= '0;
    else if (state == ACCESS && !m_apb_pready)
      wait_cnt <= wait_cnt + 8'd1;
  end

  assign timeout = (state == ACCESS) && !m_apb_pready && (wait_cnt == LAST_WAIT);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Read commands carry zero data/strobes so the bus never leaks stale write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      prot_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= cmd_write;
        prot_q  <= cmd_prot;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_write ? cmd_wdata : '0;
        strb_q  <= cmd_write ? cmd_strb : '0;
      end
      if (done) begin
        err_q   <= m_apb_pslverr;
        rdata_q <= (write_q || m_apb_pslverr) ? '0 : m_apb_prdata;
      end else if (timeout) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    m_apb_psel    = 1'b0;
    m_apb_penable = 1'b0;
    m_apb_pwrite  = 1'b0;
    m_apb_pprot   = '0;
    m_apb_paddr   = '0;
    m_apb_pwdata  = '0;
    m_apb_pstrb   = '0;
    case (state)
      IDLE: begin
        cmd_ready = rst;
        if (cmd_valid)
          state_next = SETUP;
      end
      SETUP, ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = (state == ACCESS);
        m_apb_pwrite  = write_q;
        m_apb_pprot   = prot_q;
        m_apb_paddr   = addr_q;
        m_apb_pwdata  = wdata_q;
        m_apb_pstrb   = strb_q;
        if (state == SETUP)
          state_next = ACCESS;
        else if (done || timeout)
          state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
